// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux: addressed or round-robin grant into a one-beat output register (1-cycle latency).
// Optional packet lock under `STREAM_MUX_LOCK_EN`: a packet holds the grant until its last beat.
module stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch_q;

  logic             can_accept;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  assign can_accept = !out_valid_q || out_ready;

  // Round-robin scans from the highest offset down so the nearest valid channel past ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (i == (int'(ptr_q) + k) % NUM_CH && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
    end else if (int'(sel) < NUM_CH) begin
      grant_vld = 1'b1;
      grant_idx = sel;
    end
    if (lock_q) begin
      grant_vld = 1'b1;
      grant_idx = lock_ch_q;
    end
  end

  always_comb begin
    in_ready  = '0;
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = can_accept && grant_vld && (grant_idx == SEL_W'(i));
      if (in_ready[i]) begin
        beat_data = in_data[i*WIDTH +: WIDTH];
        beat_last = in_last[i];
      end
    end
  end

  assign xfer  = |(in_valid & in_ready);
  assign ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_last_q  <= beat_last;
        out_ch_q    <= grant_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Mid-packet beats leave ptr alone; the closing beat moves it past the locked channel.
      if (mode && xfer && (!lock_q || beat_last)) begin
        ptr_q <= ptr_d;
      end
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer) begin
      if (!beat_last) begin
        lock_q    <= 1'b1;
        lock_ch_q <= grant_idx;
      end else begin
        lock_q    <= 1'b0;
      end
    end
  end
`else
  assign lock_q    = 1'b0;
  assign lock_ch_q = '0;
`endif

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux (NUM_CH=4, WIDTH=8, SEL_W=3): vector table plus hand sequences
// for back-pressure, async reset mid-packet and packet lock (both builds of STREAM_MUX_LOCK_EN).
module tb_stream_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;
  localparam logic [31:0] DEF_DATA = 32'hD3C2B1A0;

  logic                    clk;
  logic                    rst_n;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_last;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_last;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  int n_cmp = 0;
  int n_err = 0;

  stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [2:0]  exp_och;
    logic        exp_olast;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [2:0] s, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic r, input logic [3:0] er, input logic eov,
                     input logic [7:0] eod, input logic [2:0] ech, input logic elast);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.last = l; t.data = d; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_och = ech; t.exp_olast = elast;
    vecs.push_back(t);
  endtask

  // Inputs are already applied; check in_ready, clock once, check the output register.
  task automatic cyc(input string name, input logic [3:0] er, input logic eov,
                     input logic [7:0] eod, input logic [2:0] ech, input logic elast);
    #1;
    chk({name, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    chk({name, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({name, ".out_data"}, 32'(out_data), 32'(eod));
    chk({name, ".out_ch"}, 32'(out_ch), 32'(ech));
    chk({name, ".out_last"}, 32'(out_last), 32'(elast));
  endtask

  task automatic drive(input logic m, input logic [2:0] s, input logic [3:0] v,
                       input logic [3:0] l, input logic [31:0] d, input logic r);
    mode = m; sel = s; in_valid = v; in_last = l; in_data = d; out_ready = r;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 4'b0000, 4'b1111, DEF_DATA, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    chk("reset.in_ready", 32'(in_ready), 32'h1);
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    chk("reset.out_data", 32'(out_data), 32'h0);
    chk("reset.out_ch", 32'(out_ch), 32'h0);
    chk("reset.out_last", 32'(out_last), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //  mode sel valid    last     data          rdy  exp_rdy  ov  od     och   olast
    add(1'b0, 3'd2, 4'b1111, 4'b1111, 32'hD3A5B1A0, 1'b1, 4'b0100, 1'b1, 8'hA5, 3'd2, 1'b1);
    add(1'b0, 3'd1, 4'b0010, 4'b1111, DEF_DATA,     1'b1, 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b1);
    add(1'b0, 3'd3, 4'b0000, 4'b1111, DEF_DATA,     1'b1, 4'b1000, 1'b0, 8'hB1, 3'd1, 1'b1);
    add(1'b0, 3'd5, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b0000, 1'b0, 8'hB1, 3'd1, 1'b1);
    add(1'b0, 3'd4, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b0000, 1'b0, 8'hB1, 3'd1, 1'b1);
    add(1'b0, 3'd0, 4'b0001, 4'b1110, DEF_DATA,     1'b1, 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b0);
    add(1'b0, 3'd0, 4'b0001, 4'b1111, 32'hD3C2B15A, 1'b1, 4'b0001, 1'b1, 8'h5A, 3'd0, 1'b1);
    add(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b1);
    add(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b1);
    add(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b0100, 1'b1, 8'hC2, 3'd2, 1'b1);
    add(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b1000, 1'b1, 8'hD3, 3'd3, 1'b1);
    add(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA,     1'b1, 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b1);
    add(1'b1, 3'd0, 4'b1001, 4'b1111, DEF_DATA,     1'b1, 4'b1000, 1'b1, 8'hD3, 3'd3, 1'b1);
    add(1'b1, 3'd0, 4'b0110, 4'b1111, DEF_DATA,     1'b1, 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b1);
    add(1'b1, 3'd0, 4'b0001, 4'b1111, DEF_DATA,     1'b1, 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b1);
    add(1'b1, 3'd0, 4'b0000, 4'b1111, DEF_DATA,     1'b1, 4'b0000, 1'b0, 8'hA0, 3'd0, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].ordy);
      cyc($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_od,
          vecs[i].exp_och, vecs[i].exp_olast);
    end

    // Back-pressure: empty register accepts ch1, then three stalled cycles hold it.
    drive(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA, 1'b0);
    cyc("bp_load", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) cyc($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, 8'hB1, 3'd1, 1'b1);
    out_ready = 1'b1;
    cyc("bp_release", 4'b0100, 1'b1, 8'hC2, 3'd2, 1'b1);
    in_valid = 4'b0000;
    cyc("bp_drain", 4'b0000, 1'b0, 8'hC2, 3'd2, 1'b1);

    // Async reset with a beat held: out_valid must drop with no clock edge.
    drive(1'b1, 3'd0, 4'b1111, 4'b1111, DEF_DATA, 1'b0);
    cyc("rst_load", 4'b1000, 1'b1, 8'hD3, 3'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async.out_valid", 32'(out_valid), 32'h0);
    chk("rst_async.out_data", 32'(out_data), 32'h0);
    chk("rst_async.out_ch", 32'(out_ch), 32'h0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    cyc("rst_restart", 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b1);

    // ch1 sends a 3-beat packet while ch0 and ch2 stay valid; ptr currently 1.
    drive(1'b1, 3'd0, 4'b0111, 4'b1101, DEF_DATA, 1'b1);
`ifdef STREAM_MUX_LOCK_EN
    cyc("lock_b0", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b0);
    cyc("lock_b1", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b0);
    in_last = 4'b1111;
    cyc("lock_b2", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b1);
    cyc("lock_b3", 4'b0100, 1'b1, 8'hC2, 3'd2, 1'b1);
`else
    cyc("rr_b0", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b0);
    cyc("rr_b1", 4'b0100, 1'b1, 8'hC2, 3'd2, 1'b1);
    in_last = 4'b1111;
    cyc("rr_b2", 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b1);
    cyc("rr_b3", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
